// File: rtl/move_fetch_if.sv
`default_nettype none
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 16
`endif
//----------------------------------------------------------------------
// move_fetch_if -- start/RAM-read/move-stream signals of move_fetch. Rev 1.0
//----------------------------------------------------------------------
interface move_fetch_if #(
   parameter int RAM_WIDTH          = 16,
   parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS)
);
   logic                          fetch_start;
   logic                          white_to_move;
   logic [MAX_POSITIONS_LOG2:0]   move_count;
   logic                          sort_complete;
   logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr;
   logic [RAM_WIDTH-1:0]          ram_rd_data;
   logic [RAM_WIDTH-1:0]          move_data;
   logic [MAX_POSITIONS_LOG2-1:0] move_index;
   logic                          move_valid;
   logic                          move_ready;
   logic                          fetch_busy;
   logic                          fetch_done;
   logic [MAX_POSITIONS_LOG2:0]   legal_count;

   modport master (
      output fetch_start, white_to_move, move_count, sort_complete,
             ram_rd_data, move_ready,
      input  ram_rd_addr, move_data, move_index, move_valid,
             fetch_busy, fetch_done, legal_count
   );

   modport slave (
      input  fetch_start, white_to_move, move_count, sort_complete,
             ram_rd_data, move_ready,
      output ram_rd_addr, move_data, move_index, move_valid,
             fetch_busy, fetch_done, legal_count
   );
endinterface
`default_nettype wire

// File: rtl/move_fetch.sv
`default_nettype none
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 16
`endif
//----------------------------------------------------------------------
// move_fetch -- streams the legal entries of the sorted move RAM. Rev 1.0
//----------------------------------------------------------------------
module move_fetch #(
   parameter int RAM_WIDTH          = 0,
   parameter int EVAL_WIDTH         = 0,
   parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS)
) (
   input  wire logic   clk,
   input  wire logic   reset,
   move_fetch_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SORT = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_RD   = 3'd3,
      ST_CAPTURE   = 3'd4,
      ST_PRESENT   = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   localparam logic [MAX_POSITIONS_LOG2:0] c_max_count =
      (MAX_POSITIONS_LOG2 + 1)'(`MAX_POSITIONS);

   state_t                      r_state;
   logic                        r_white;
   logic [MAX_POSITIONS_LOG2:0] r_count;
   logic [MAX_POSITIONS_LOG2:0] r_index;

   logic [MAX_POSITIONS_LOG2:0] w_index_inc;
   logic                        w_last;
   logic [RAM_WIDTH-1:0]        w_entry;
   logic                        w_illegal;

   assign w_index_inc = r_index + 1'b1;
   assign w_last      = (w_index_inc == r_count);
   assign w_entry     = bus.ram_rd_data;
   // The side that just moved must not be left in check.
   assign w_illegal   = r_white ? w_entry[EVAL_WIDTH+1] : w_entry[EVAL_WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_white         <= 1'b0;
         r_count         <= '0;
         r_index         <= '0;
         bus.ram_rd_addr <= '0;
         bus.move_data   <= '0;
         bus.move_index  <= '0;
         bus.move_valid  <= 1'b0;
         bus.fetch_busy  <= 1'b0;
         bus.fetch_done  <= 1'b0;
         bus.legal_count <= '0;
      end else begin
         bus.fetch_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.fetch_start) begin
                  r_white         <= bus.white_to_move;
                  r_count         <= (bus.move_count > c_max_count) ? c_max_count
                                                                    : bus.move_count;
                  r_index         <= '0;
                  bus.legal_count <= '0;
                  bus.fetch_busy  <= 1'b1;
                  r_state         <= ST_WAIT_SORT;
               end
            end
            ST_WAIT_SORT: begin
               if (bus.sort_complete) begin
                  if (r_count == '0) begin
                     bus.fetch_done <= 1'b1;
                     r_state        <= ST_DONE;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               bus.ram_rd_addr <= r_index[MAX_POSITIONS_LOG2-1:0];
               r_state         <= ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
               r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (!w_illegal) begin
                  bus.move_data   <= w_entry;
                  bus.move_index  <= r_index[MAX_POSITIONS_LOG2-1:0];
                  bus.move_valid  <= 1'b1;
                  bus.legal_count <= bus.legal_count + 1'b1;
                  r_state         <= ST_PRESENT;
               end else begin
                  r_index <= w_index_inc;
                  if (w_last) begin
                     bus.fetch_done <= 1'b1;
                     r_state        <= ST_DONE;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_PRESENT: begin
               if (bus.move_ready) begin
                  bus.move_valid <= 1'b0;
                  r_index        <= w_index_inc;
                  if (w_last) begin
                     bus.fetch_done <= 1'b1;
                     r_state        <= ST_DONE;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               bus.fetch_busy <= 1'b0;
               r_state        <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_move_fetch.sv
`timescale 1ns/1ps
`default_nettype none
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 16
`endif
// tb_move_fetch -- randomized fetches against a queue model of the legal-move list.
module tb_move_fetch;
   localparam int RW   = 16;
   localparam int EW   = 12;
   localparam int AW   = $clog2(`MAX_POSITIONS);
   localparam int MAXP = `MAX_POSITIONS;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   move_fetch_if #(.RAM_WIDTH(RW), .MAX_POSITIONS_LOG2(AW)) bus ();

   move_fetch #(
      .RAM_WIDTH(RW), .EVAL_WIDTH(EW), .MAX_POSITIONS_LOG2(AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // RAM: the DUT's address register plus one output register gives the 2-cycle latency.
   logic [RW-1:0] mem [MAXP];
   always @(posedge clk) bus.ram_rd_data <= mem[bus.ram_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int emitted[$];
   int exp_legal = 0;
   int done_cnt  = 0;
   int done_cyc  = 0;
   bit chk_en    = 1'b0;
   int ready_mode = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Model: legal entries are the addresses below the saturated count whose mover is not in check.
   task automatic build_model(input int count, input bit white);
      int n;
      n = (count > MAXP) ? MAXP : count;
      exp_q.delete();
      emitted.delete();
      for (int a = 0; a < n; a++)
         if (!(white ? mem[a][EW+1] : mem[a][EW])) exp_q.push_back(a);
      exp_legal = exp_q.size();
   endtask

   task automatic fill_legal();
      for (int a = 0; a < MAXP; a++) begin
         mem[a] = RW'($urandom);
         mem[a][EW]   = 1'b0;
         mem[a][EW+1] = 1'b0;
      end
   endtask

   task automatic fill_random();
      for (int a = 0; a < MAXP; a++) begin
         mem[a] = RW'($urandom);
         mem[a][EW]   = ($urandom_range(0, 3) == 0);
         mem[a][EW+1] = ($urandom_range(0, 3) == 0);
      end
   endtask

   // Downstream acceptance patterns.
   initial begin
      int stall = 0;
      bus.move_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: bus.move_ready = 1'b1;
            1: bus.move_ready = 1'($urandom_range(0, 1));
            3: bus.move_ready = bus.move_valid && (bus.move_index != AW'(1));
            4: begin
               if (bus.move_valid) begin
                  stall++;
                  bus.move_ready = (stall > 5);
               end else begin
                  stall = 0;
                  bus.move_ready = 1'($urandom_range(0, 1));
               end
            end
            default: bus.move_ready = 1'b0;
         endcase
      end
   end

   // Compare process: every presented entry must be the model's next legal entry.
   initial begin
      bit pv = 1'b0;
      bit pr = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en && !reset) begin
            if (pv && !pr) check("valid_held_until_ready", bus.move_valid, 1);
            if (bus.move_valid) begin
               if (exp_q.size() == 0) begin
                  check("spurious_move_valid", bus.move_valid, 0);
               end else begin
                  check("move_index", bus.move_index, exp_q[0]);
                  check("move_data", bus.move_data, mem[exp_q[0]]);
                  if (bus.move_ready) begin
                     emitted.push_back(int'(bus.move_index));
                     void'(exp_q.pop_front());
                  end
               end
            end
            if (bus.fetch_done) begin
               check("done_with_entries_left", exp_q.size(), 0);
               check("legal_count_at_done", bus.legal_count, exp_legal);
               check("busy_at_done", bus.fetch_busy, 1);
               done_cnt++;
               done_cyc = cyc;
            end
            pv = bus.move_valid;
            pr = bus.move_ready;
         end else begin
            pv = 1'b0;
            pr = 1'b0;
         end
      end
   end

   task automatic start_fetch(input int count, input bit white, output int sc);
      @(posedge clk); #1;
      bus.fetch_start   = 1'b1;
      bus.white_to_move = white;
      bus.move_count    = count[AW:0];
      sc = cyc;
      @(posedge clk); #1;
      bus.fetch_start   = 1'b0;
      bus.white_to_move = 1'($urandom);
      bus.move_count    = (AW+1)'($urandom);
   endtask

   task automatic run_fetch(input int count, input bit white, input int sort_delay,
                            input bit extra_start, input bit toggle_sort, output int lat);
      int sc, d0, addr0;
      bit got;
      build_model(count, white);
      d0    = done_cnt;
      addr0 = int'(bus.ram_rd_addr);
      bus.sort_complete = (sort_delay == 0);
      start_fetch(count, white, sc);
      check("busy_after_start", bus.fetch_busy, 1);
      for (int i = 0; i < sort_delay; i++) begin
         check("addr_still_while_unsorted", bus.ram_rd_addr, addr0);
         check("no_valid_while_unsorted", bus.move_valid, 0);
         @(posedge clk); #1;
      end
      bus.sort_complete = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
         if (toggle_sort) bus.sort_complete = 1'($urandom_range(0, 1));
         bus.fetch_start = extra_start && (i == 3);
      end
      bus.fetch_start   = 1'b0;
      bus.sort_complete = 1'b1;
      lat = done_cyc - sc;
      check("fetch_finished", got, 1);
      repeat (4) @(posedge clk);
      #1;
      check("single_done_pulse", done_cnt - d0, 1);
      check("busy_cleared", bus.fetch_busy, 0);
      check("legal_count_held", bus.legal_count, exp_legal);
   endtask

   initial begin
      int lat, sc;
      bit found;
      #50_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int lat, sc;
      bit found;
      bus.fetch_start   = 1'b0;
      bus.white_to_move = 1'b0;
      bus.move_count    = '0;
      bus.sort_complete = 1'b0;
      fill_legal();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ram_rd_addr", bus.ram_rd_addr, 0);
      check("rst_move_data", bus.move_data, 0);
      check("rst_move_index", bus.move_index, 0);
      check("rst_move_valid", bus.move_valid, 0);
      check("rst_fetch_busy", bus.fetch_busy, 0);
      check("rst_fetch_done", bus.fetch_done, 0);
      check("rst_legal_count", bus.legal_count, 0);
      @(posedge clk); #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Three legal entries, ready always high.
      fill_legal();
      ready_mode = 0;
      run_fetch(3, 1'b0, 0, 1'b0, 1'b0, lat);
      check("all_legal_emit_count", emitted.size(), 3);
      if (emitted.size() == 3)
         check("all_legal_order", emitted[0]*100 + emitted[1]*10 + emitted[2], 12);
      check("all_legal_count_lit", bus.legal_count, 3);

      // White moved; entry 1 leaves white in check, entry 2's black flag is irrelevant.
      fill_legal();
      mem[1][EW+1] = 1'b1;
      mem[2][EW]   = 1'b1;
      run_fetch(4, 1'b1, 0, 1'b0, 1'b0, lat);
      check("skip_emit_count", emitted.size(), 3);
      if (emitted.size() == 3)
         check("skip_order", emitted[0]*100 + emitted[1]*10 + emitted[2], 23);
      check("skip_count_lit", bus.legal_count, 3);

      // Empty list.
      run_fetch(0, 1'b0, 0, 1'b0, 1'b0, lat);
      check("empty_done_latency", lat, 2);
      check("empty_emit_count", emitted.size(), 0);
      check("empty_legal_count_lit", bus.legal_count, 0);

      // Sorter not finished for 10 cycles.
      fill_legal();
      run_fetch(2, 1'b0, 10, 1'b0, 1'b0, lat);
      check("late_sort_emit_count", emitted.size(), 2);

      // Downstream stalls 5 cycles per entry; a stray fetch_start mid-fetch.
      fill_random();
      ready_mode = 4;
      run_fetch(5, 1'b0, 0, 1'b1, 1'b0, lat);

      // Oversized count saturates.
      fill_random();
      ready_mode = 1;
      run_fetch(31, 1'($urandom), 1, 1'b0, 1'b1, lat);

      // Reset while entry 1 is presented.
      fill_legal();
      ready_mode = 3;
      build_model(4, 1'b0);
      bus.sort_complete = 1'b1;
      start_fetch(4, 1'b0, sc);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.move_valid && bus.move_index == AW'(1)) begin
            found = 1'b1;
            break;
         end
      end
      check("reached_entry1", found, 1);
      @(posedge clk); #1;
      reset  = 1'b1;
      chk_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_move_valid", bus.move_valid, 0);
      check("abort_fetch_done", bus.fetch_done, 0);
      check("abort_fetch_busy", bus.fetch_busy, 0);
      check("abort_legal_count", bus.legal_count, 0);
      check("abort_move_data", bus.move_data, 0);
      check("abort_move_index", bus.move_index, 0);
      check("abort_ram_rd_addr", bus.ram_rd_addr, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      chk_en     = 1'b1;
      ready_mode = 0;
      run_fetch(4, 1'b0, 0, 1'b0, 1'b0, lat);
      check("restart_emit_count", emitted.size(), 4);
      if (emitted.size() > 0) check("restart_first_index", emitted[0], 0);

      // Randomized fetches.
      ready_mode = 1;
      for (int t = 0; t < 12; t++) begin
         fill_random();
         run_fetch($urandom_range(0, 20), 1'($urandom), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/move_fetch.md
MOVE_FETCH -- requirements
Module: move_fetch

Interface
REQ-001 Parameter RAM_WIDTH, default 0, width of one move-RAM entry; overridden at instantiation.
REQ-002 Parameter EVAL_WIDTH, default 0, eval field width; entry bits [EVAL_WIDTH-1:0] hold signed eval, bit EVAL_WIDTH holds black_in_check, bit EVAL_WIDTH+1 holds white_in_check.
REQ-003 Parameter MAX_POSITIONS_LOG2, default $clog2(`MAX_POSITIONS), move-RAM address width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 fetch_start  in  1  one-cycle pulse; begin reading the sorted move list.
REQ-008 white_to_move  in  1  side that made the stored moves; sampled on the fetch_start cycle.
REQ-009 move_count  in  MAX_POSITIONS_LOG2+1  number of valid RAM entries; sampled on the fetch_start cycle.
REQ-010 sort_complete  in  1  move RAM holds a fully sorted list.
REQ-011 ram_rd_addr  out  MAX_POSITIONS_LOG2  registered read address into the move RAM.
REQ-012 ram_rd_data  in  RAM_WIDTH  entry at ram_rd_addr; valid 2 cycles after ram_rd_addr changes (address register + RAM output register).
REQ-013 move_data  out  RAM_WIDTH  current legal entry presented downstream.
REQ-014 move_index  out  MAX_POSITIONS_LOG2  RAM address the presented entry came from.
REQ-015 move_valid  out  1  move_data/move_index valid.
REQ-016 move_ready  in  1  downstream accepts the entry when move_valid && move_ready.
REQ-017 fetch_busy  out  1  high from the cycle after accepted fetch_start until fetch_done.
REQ-018 fetch_done  out  1  one-cycle pulse at end of list.
REQ-019 legal_count  out  MAX_POSITIONS_LOG2+1  entries presented in the current/last fetch.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT_SORT, ISSUE, WAIT_RD, CAPTURE, PRESENT, DONE.
REQ-021 IDLE: fetch_start -> latch white_to_move and move_count, clear index and legal_count, go to WAIT_SORT; otherwise stay.
REQ-022 WAIT_SORT: stay until sort_complete=1; then go to DONE if the latched count is 0, else go to ISSUE.
REQ-023 ISSUE: ram_rd_addr <= index; go to WAIT_RD.
REQ-024 WAIT_RD: one cycle, unconditional, go to CAPTURE (covers the 2-cycle RAM latency).
REQ-025 CAPTURE: sample ram_rd_data; illegal = white_to_move ? bit EVAL_WIDTH+1 : bit EVAL_WIDTH.
REQ-026 CAPTURE, legal: move_data <= ram_rd_data, move_index <= index, move_valid <= 1, legal_count += 1, go to PRESENT.
REQ-027 CAPTURE, illegal: drop the entry; index += 1; go to DONE if index+1 == count, else go to ISSUE.
REQ-028 PRESENT: hold move_valid, move_data and move_index stable until move_ready=1.
REQ-029 PRESENT, on handshake: move_valid <= 0, index += 1, go to DONE if index+1 == count, else go to ISSUE.
REQ-030 DONE: fetch_done=1 for exactly one cycle, fetch_busy <= 0, go to IDLE.
REQ-031 Entries SHALL be emitted in ascending RAM address order with no reordering; ordering by eval is the sorter's responsibility.
REQ-032 fetch_start SHALL be ignored in every state except IDLE.
REQ-033 move_count greater than `MAX_POSITIONS SHALL be saturated to `MAX_POSITIONS when latched.
REQ-034 index SHALL be MAX_POSITIONS_LOG2+1 bits wide, so a count of `MAX_POSITIONS terminates without wrap-around.
REQ-035 If sort_complete falls while the FSM is in a state past WAIT_SORT, the fetch SHALL continue unaffected.
REQ-036 move_ready asserted while move_valid=0 SHALL have no effect.
REQ-037 legal_count SHALL hold its final value after DONE until the next accepted fetch_start.

Reset
REQ-038 On reset: state=IDLE; ram_rd_addr, move_data, move_index, legal_count = 0; move_valid, fetch_busy, fetch_done = 0.
REQ-039 Reset asserted mid-fetch SHALL abort immediately: no fetch_done pulse, and move_valid=0 on the next cycle.

Verification
REQ-040 count=3, all legal, sort_complete already high, move_ready=1 -> indices 0,1,2 emitted in order, legal_count=3, one fetch_done pulse.
REQ-041 count=4, white_to_move=1, white_in_check set on entry 1 -> indices 0,2,3 emitted, legal_count=3.
REQ-042 count=0 -> fetch_done pulses 2 cycles after fetch_start (once sort_complete is high), move_valid never rises, legal_count=0.
REQ-043 sort_complete held low 10 cycles after fetch_start -> ram_rd_addr unchanged and no move_valid until sort_complete rises.
REQ-044 move_ready held low 5 cycles during PRESENT -> move_data and move_index stable throughout; a second fetch_start during the fetch is ignored.
REQ-045 reset asserted during PRESENT of entry 1 -> all outputs 0 next cycle; a new fetch afterwards starts at index 0.
